// File: rtl/dmem_block_mover.sv
// dmem_block_mover
// DMA-style helper that drives the data_memory port to copy a block of words
// from one address range to another, or to fill a range with a constant.
// Every output, including the memory strobes, comes straight from a flop.
// Copies alternate one read cycle with one write cycle. Fills write on
// consecutive cycles. Addresses advance by ADDR_STEP and wrap modulo 2^32.

module dmem_block_mover #(
    parameter int ADDR_STEP = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_done,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [31:0]      address,
    output logic [31:0]      write_data,
    input  logic [31:0]      read_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0]      STEP_C = 32'(ADDR_STEP);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic             MODE_COPY = 1'b0;

    // Control state
    state_t           state_q;
    logic             mode_q;
    logic [31:0]      src_q;        // address of the next word to read
    logic [31:0]      dst_q;        // address of the word being / next written
    logic [CNT_W-1:0] rem_q;        // words still to be written

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] words_done_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [31:0]      address_q;
    logic [31:0]      write_data_q; // captured copy word, or the fill pattern

    // Next-value helpers shared by several state branches
    logic [31:0]      src_d;
    logic [31:0]      dst_d;
    logic [CNT_W-1:0] rem_d;
    logic [CNT_W-1:0] words_done_d;
    logic             last_word_d;
    logic             count_zero_d;

    assign src_d        = src_q + STEP_C;
    assign dst_d        = dst_q + STEP_C;
    assign rem_d        = rem_q - ONE_C;
    assign words_done_d = words_done_q + ONE_C;
    assign last_word_d  = (rem_q == ONE_C);
    assign count_zero_d = (count == '0);

    assign busy       = busy_q;
    assign done       = done_q;
    assign words_done = words_done_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign address    = address_q;
    assign write_data = write_data_q;

    // Transfer FSM: sequences the operation and registers every output for the cycle ahead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            src_q        <= 32'h0000_0000;
            dst_q        <= 32'h0000_0000;
            rem_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_done_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= 32'h0000_0000;
            write_data_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Strobes stay low; address and write_data keep their last values
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    if (start) begin
                        mode_q       <= mode;
                        src_q        <= src_addr;
                        dst_q        <= dst_addr;
                        rem_q        <= count;
                        words_done_q <= '0;
                        if (count_zero_d) begin
                            // Nothing to move: report completion without touching memory
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (mode == MODE_COPY) begin
                            state_q    <= ST_RD;
                            busy_q     <= 1'b1;
                            mem_read_q <= 1'b1;
                            address_q  <= src_addr;
                        end else begin
                            state_q      <= ST_WR;
                            busy_q       <= 1'b1;
                            mem_write_q  <= 1'b1;
                            address_q    <= dst_addr;
                            write_data_q <= fill_data;
                        end
                    end
                end

                ST_RD: begin
                    // Memory read is combinational, so the word is valid this cycle
                    state_q      <= ST_WR;
                    src_q        <= src_d;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b1;
                    address_q    <= dst_q;
                    write_data_q <= read_data;
                end

                ST_WR: begin
                    dst_q        <= dst_d;
                    rem_q        <= rem_d;
                    words_done_q <= words_done_d;
                    if (last_word_d) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end else if (mode_q == MODE_COPY) begin
                        state_q     <= ST_RD;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                        address_q   <= src_q;
                    end else begin
                        // Fill keeps writing the same pattern on consecutive cycles
                        state_q     <= ST_WR;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b1;
                        address_q   <= dst_d;
                    end
                end

                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end

                default: begin
                    // Unreachable encoding: park safely with the bus released
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_block_mover.md
# dmem_block_mover

Bus initiator for the MIPS `data_memory` block: on a start pulse it copies a block of words from a source to a destination address range, or fills a range with a constant. It drives the memory's MemRead/MemWrite/address/write_data pins and samples read_data. It sits beside the datapath as a DMA-style helper for memory initialisation and self-test, and is multiplexed onto the memory port by the top level.

## Interface
Parameters:
- `ADDR_STEP`, default 1: address increment per word (use 4 for byte-addressed memory).
- `CNT_W`, default 16: width of the word-count field.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; sampled with start.
- `src_addr`  in  32  first source word address (copy only); sampled with start.
- `dst_addr`  in  32  first destination word address; sampled with start.
- `count`  in  CNT_W  number of words to move; sampled with start.
- `fill_data`  in  32  fill pattern (fill only); sampled with start.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse at operation end.
- `words_done`  out  CNT_W  number of words written so far; holds its final value until the next start.
- `MemRead`  out  1  to data_memory.
- `MemWrite`  out  1  to data_memory.
- `address`  out  32  to data_memory.
- `write_data`  out  32  to data_memory.
- `read_data`  in  32  from data_memory. Combinational read: valid in the same cycle as address/MemRead.

## Operation
- All outputs are registered.
- Reset values: MemRead=0, MemWrite=0, address=0, write_data=0, busy=0, done=0, words_done=0, state=IDLE.
- States: IDLE, RD, WR, DONE.
- IDLE, start=1:
  - Latch src, dst, fill_data and mode.
  - Load the remaining-word counter with count and clear words_done.
  - If count=0, go to DONE; no memory access is made.
  - Otherwise go to RD (copy) or WR (fill).
- RD:
  - Drive MemRead=1, MemWrite=0, address=src.
  - At the end of the cycle, capture read_data into the data register and advance src by ADDR_STEP.
  - Go to WR.
- WR:
  - Drive MemWrite=1, MemRead=0, address=dst.
  - write_data = captured word (copy) or fill_data (fill).
  - At the end of the cycle: advance dst by ADDR_STEP, increment words_done, decrement remaining.
  - If remaining reaches 0, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
- DONE:
  - done=1 and busy=0 for exactly one cycle; MemRead=MemWrite=0.
  - Return to IDLE.
- In IDLE and DONE, MemRead=MemWrite=0, and address/write_data hold their last values.
- MemRead and MemWrite are never high in the same cycle.
- Address arithmetic is modulo 2^32; 0xFFFFFFFF + 1 wraps to 0 without error.
- Overlapping ranges copy strictly forward, with no overlap correction.
- start while busy (or in DONE) is ignored.

## Timing
- Accepted start at edge k: busy=1 from cycle k+1.
- Copy of N≥1 words:
  - First RD is in cycle k+1.
  - Word i uses RD in cycle k+1+2i and WR in cycle k+2+2i.
  - done pulses in cycle k+1+2N.
  - busy is high for 2N cycles.
- Fill of N≥1 words: WR cycles k+1 … k+N; done in cycle k+N+1.
- count=0: done pulses in cycle k+1 and busy never rises.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously); the FSM returns to IDLE.
  - Words already written remain in memory; no done pulse occurs.
- start can be accepted again in the IDLE cycle that follows DONE.

## Test plan
- **Copy:** preload mem[0..3]=0xA0,0xA1,0xA2,0xA3; start mode=0, src=0, dst=16, count=4.
  - Expect 8 busy cycles with alternating MemRead/MemWrite pulses, then a done pulse.
  - After done: mem[16..19]=0xA0..0xA3 and words_done=4.
- **Fill:** start mode=1, dst=32, count=5, fill_data=0xDEADBEEF.
  - Expect MemWrite high for 5 consecutive cycles on addresses 32..36, then done in the 6th cycle.
  - MemRead stays 0 throughout.
- **Zero count:** start with count=0.
  - Expect done one cycle later, busy never high, no MemRead/MemWrite activity, words_done=0.
- **Start while busy:** during a count=4 copy, pulse start with different addresses.
  - Expect it to be ignored: the original transfer completes unchanged with done after 8 busy cycles.
- **Reset mid-op:** assert rst during the WR of word 2 of a count=8 copy.
  - Expect all outputs 0 immediately and no done pulse.
  - mem holds words 0–1 only.
  - A subsequent start runs normally.
- **Wrap:** fill with dst=0xFFFFFFFE, count=3.
  - Expect writes to 0xFFFFFFFE, 0xFFFFFFFF and 0x00000000, with done after the third write.
